aig_sdnf_extract: RTL
=====================

AIG_SDNF_EXTRACT -- requirements
Module: aig_sdnf_extract

Interface
REQ-001 SHALL have parameter NUM_IN, default 3, the number of primary inputs x1..xNUM_IN (legal 1..8).
REQ-002 SHALL have parameter MAX_NODES, default 32, the AND-node storage capacity (legal 1..64).
REQ-003 SHALL define literal width LW = clog2(NUM_IN+MAX_NODES+1)+1; literal = {index, inv}, bit0 = invert; index 0 = const 0, 1..NUM_IN = xk, NUM_IN+j = j-th loaded node.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  begin a job when in IDLE; ignored elsewhere.
REQ-007 out_lit  input  LW  output literal, sampled on accepted start.
REQ-008 node_valid/node_ready  input/output  1  node load handshake.
REQ-009 node_a, node_b  input  LW  AND-node fan-in literals.
REQ-010 node_last  input  1  marks final node of the netlist.
REQ-011 m_valid/m_ready  output/input  1  minterm stream handshake.
REQ-012 m_vector  output  NUM_IN  minterm; bit k-1 = value of xk.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse at job completion.
REQ-015 err  output  1  one-cycle pulse on a rejected netlist.
REQ-016 count  output  NUM_IN+1  minterms emitted in the current or last job.

Function
REQ-017 SHALL implement FSM IDLE, LOAD, EVAL, EMIT, FIN.
REQ-018 IDLE: start=1 -> LOAD; latch out_lit; clear count and node count.
REQ-019 LOAD: node_ready=1; each cycle with node_valid=1 stores node j at index NUM_IN+j; node_last=1 -> EVAL with vector=0.
REQ-020 EVAL: one node evaluated per cycle, a node value = (A^invA)&(B^invB); K nodes take K cycles, plus 1 cycle to resolve out_lit (K+1 cycles per vector).
REQ-021 Result 1 -> EMIT; m_valid=1 with m_vector=current vector, held stable until m_ready=1; count increments on the handshake.
REQ-022 Result 0 or EMIT handshake -> next vector in EVAL; after vector 2^NUM_IN-1 -> FIN.
REQ-023 FIN: done=1 for one cycle -> IDLE; count holds until the next start.
REQ-024 m_valid=0 and node_ready=0 outside EMIT and LOAD respectively.
REQ-025 Zero-minterm function: no m_valid, done asserted, count=0; all-ones function: 2^NUM_IN minterms in ascending order.

Reset
REQ-026 rst_n=0 SHALL force IDLE, node count 0, all node values 0, and m_valid, node_ready, busy, done, err, count, m_vector to 0 asynchronously, including mid-LOAD/EVAL/EMIT.
REQ-027 After reset release, the first start SHALL behave as a fresh job.

Configuration
REQ-028 Macro AIG_SDNF_CHECK_EN SHALL gate netlist checking.
REQ-029 With it: a node literal index >= its own index, a node beyond MAX_NODES, or an out_lit index > NUM_IN+K SHALL pulse err, emit nothing, return to IDLE without done.
REQ-030 Without it: err tied 0; nodes beyond MAX_NODES dropped; invalid references give undefined minterms but the FSM still completes with done.

Verification
REQ-031 NUM_IN=3, node n4=(x1,x2) lits {1,0},{2,0}, out_lit {4,0} -> minterms 3'b011, 3'b111, count=2, done.
REQ-032 Single node n4=(~x1,~x1), out_lit {4,1} -> minterms 001, 011, 101, 111, count=4.
REQ-033 out_lit {0,1} (const 1), any one node -> 8 minterms 000..111, count=8; out_lit {0,0} -> none, count=0.
REQ-034 Case of REQ-031 with m_ready held low 5 cycles at first minterm -> m_vector=3'b011 and m_valid stable throughout, no vector skipped.
REQ-035 With AIG_SDNF_CHECK_EN, first node lits {5,0},{1,0} -> err pulse, no m_valid, busy=0 next cycle.
REQ-036 rst_n low during EMIT -> all outputs 0 immediately; subsequent REQ-031 job yields correct result.

Source files
------------

// File: rtl/aig_sdnf_extract_if.sv
// aig_sdnf_extract_if: job control, AIG node-load and minterm stream bundle.
// Ports: start/out_lit, node_valid/ready/a/b/last, m_valid/ready/vector,
//        busy, done, err, count. master = netlist source, slave = extractor.
interface aig_sdnf_extract_if #(
   parameter int NUM_IN    = 3,
   parameter int MAX_NODES = 32
);
   localparam int LW = $clog2(NUM_IN + MAX_NODES + 1) + 1;

   logic              start;
   logic [LW-1:0]     out_lit;
   logic              node_valid;
   logic              node_ready;
   logic [LW-1:0]     node_a;
   logic [LW-1:0]     node_b;
   logic              node_last;
   logic              m_valid;
   logic              m_ready;
   logic [NUM_IN-1:0] m_vector;
   logic              busy;
   logic              done;
   logic              err;
   logic [NUM_IN:0]   count;

   modport master (
      output start, out_lit, node_valid, node_a, node_b,
      output node_last, m_ready,
      input  node_ready, m_valid, m_vector,
      input  busy, done, err, count
   );

   modport slave (
      input  start, out_lit, node_valid, node_a, node_b,
      input  node_last, m_ready,
      output node_ready, m_valid, m_vector,
      output busy, done, err, count
   );
endinterface

// File: rtl/aig_sdnf_extract.sv
// aig_sdnf_extract: loads an AIG netlist, then sweeps all input vectors
// and streams every vector where out_lit is 1 (the SDNF minterms).
// Ports: clk, rst_n (async, active low), bus (aig_sdnf_extract_if.slave).
// Option: define AIG_SDNF_CHECK_EN to reject malformed netlists with err.
module aig_sdnf_extract #(
   parameter int NUM_IN    = 3,
   parameter int MAX_NODES = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   aig_sdnf_extract_if.slave bus
);
   localparam int LW = $clog2(NUM_IN + MAX_NODES + 1) + 1;
   localparam int IW = LW - 1;
   localparam int CW = $clog2(MAX_NODES + 1);

   typedef enum logic [2:0] {
      IDLE, LOAD, EVAL, EMIT, FIN
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [LW-1:0]        r_out;
   logic [LW-1:0]        r_a [MAX_NODES];
   logic [LW-1:0]        r_b [MAX_NODES];
   logic [MAX_NODES-1:0] r_val;
   logic [CW-1:0]        r_k;
   logic [CW-1:0]        r_eidx;
   logic [NUM_IN-1:0]    r_vec;
   logic [NUM_IN:0]      r_count;

   logic [LW-1:0]        w_cur_a;
   logic [LW-1:0]        w_cur_b;
   logic                 w_node_val;
   logic                 w_out_val;
   logic                 w_eval_end;
   logic                 w_last_vec;
   logic                 w_full;
   logic                 w_store;
   logic                 w_reject;

   // Value of a literal under the current vector and node values.
   function automatic logic lit_val(
      input logic [LW-1:0]        lit,
      input logic [NUM_IN-1:0]    vec,
      input logic [MAX_NODES-1:0] vals
   );
      logic v;
      v = 1'b0;
      for (int k = 0; k < NUM_IN; k++)
         if (lit[LW-1:1] == IW'(k + 1)) v = vec[k];
      for (int j = 0; j < MAX_NODES; j++)
         if (lit[LW-1:1] == IW'(NUM_IN + 1 + j)) v = vals[j];
      return v ^ lit[0];
   endfunction

   always_comb begin
      w_cur_a = '0;
      w_cur_b = '0;
      for (int j = 0; j < MAX_NODES; j++) begin
         if (r_eidx == CW'(j)) begin
            w_cur_a = r_a[j];
            w_cur_b = r_b[j];
         end
      end
   end

   assign w_node_val = lit_val(w_cur_a, r_vec, r_val) &
                       lit_val(w_cur_b, r_vec, r_val);
   assign w_out_val  = lit_val(r_out, r_vec, r_val);
   // Nodes are topologically ordered, so slot r_eidx only reads
   // slots already refreshed for this vector.
   assign w_eval_end = (r_eidx == r_k);
   assign w_last_vec = &r_vec;
   assign w_full     = (r_k == CW'(MAX_NODES));
   assign w_store    = (r_state == LOAD) && bus.node_valid && !w_full;

`ifdef AIG_SDNF_CHECK_EN
   localparam int XW = IW + 1;
   logic [XW-1:0] w_own;
   logic          w_bad_node;
   logic          w_bad_out;
   logic          r_err;

   // Index the incoming node would get; with this node stored it is
   // also the largest index out_lit may legally reference.
   assign w_own      = XW'(NUM_IN + 1) + XW'(r_k);
   assign w_bad_node = w_full ||
                       (XW'(bus.node_a[LW-1:1]) >= w_own) ||
                       (XW'(bus.node_b[LW-1:1]) >= w_own);
   assign w_bad_out  = XW'(r_out[LW-1:1]) > w_own;
   assign w_reject   = (r_state == LOAD) && bus.node_valid &&
                       (w_bad_node || (bus.node_last && w_bad_out));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_err <= 1'b0;
      else        r_err <= w_reject;
   end

   assign bus.err = r_err;
`else
   assign w_reject = 1'b0;
   assign bus.err  = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (bus.start) w_next = LOAD;
         LOAD: begin
            if (w_reject)
               w_next = IDLE;
            else if (bus.node_valid && bus.node_last)
               w_next = EVAL;
         end
         EVAL: begin
            if (w_eval_end) begin
               if (w_out_val)       w_next = EMIT;
               else if (w_last_vec) w_next = FIN;
            end
         end
         EMIT: begin
            if (bus.m_ready)
               w_next = w_last_vec ? FIN : EVAL;
         end
         FIN:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_out   <= '0;
         r_k     <= '0;
         r_eidx  <= '0;
         r_vec   <= '0;
         r_count <= '0;
         r_val   <= '0;
         for (int j = 0; j < MAX_NODES; j++) begin
            r_a[j] <= '0;
            r_b[j] <= '0;
         end
      end else begin
         r_state <= w_next;
         unique case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_out   <= bus.out_lit;
                  r_k     <= '0;
                  r_count <= '0;
               end
            end
            LOAD: begin
               if (w_store && !w_reject) begin
                  for (int j = 0; j < MAX_NODES; j++) begin
                     if (r_k == CW'(j)) begin
                        r_a[j] <= bus.node_a;
                        r_b[j] <= bus.node_b;
                     end
                  end
                  r_k <= r_k + CW'(1);
               end
               r_vec  <= '0;
               r_eidx <= '0;
            end
            EVAL: begin
               if (!w_eval_end) begin
                  for (int j = 0; j < MAX_NODES; j++)
                     if (r_eidx == CW'(j)) r_val[j] <= w_node_val;
                  r_eidx <= r_eidx + CW'(1);
               end else if (!w_out_val) begin
                  r_vec  <= r_vec + NUM_IN'(1);
                  r_eidx <= '0;
               end
            end
            EMIT: begin
               if (bus.m_ready) begin
                  r_count <= r_count + (NUM_IN + 1)'(1);
                  r_vec   <= r_vec + NUM_IN'(1);
                  r_eidx  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.node_ready = (r_state == LOAD);
   assign bus.m_valid    = (r_state == EMIT);
   assign bus.m_vector   = (r_state == EMIT) ? r_vec : '0;
   assign bus.busy       = (r_state != IDLE);
   assign bus.done       = (r_state == FIN);
   assign bus.count      = r_count;
endmodule
